// File: rtl/load_align_unit_if.sv
// Bus bundle for load_align_unit: core request, memory read port and core response.
// The unit connects through the slave modport; the surrounding core/memory use master.
interface load_align_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [4:0]        req_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_fault;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd,
    output req_ready,
    output mem_req_valid, mem_addr,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output rsp_valid, rsp_data, rsp_rd, rsp_fault,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_rd,
    input  req_ready,
    input  mem_req_valid, mem_addr,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  rsp_valid, rsp_data, rsp_rd, rsp_fault,
    output rsp_ready
  );
endinterface

// File: rtl/load_align_unit.sv
// Load-data unit: issues one or two word-aligned reads per load, merges and
// extracts the addressed bytes, and sign/zero-extends per RISC-V funct3.
module load_align_unit #(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned ADDR_W             = 32,
  parameter bit          SUPPORT_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              reset,
  load_align_unit_if.slave bus
);
  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              split_q, split_d;
  logic [XLEN-1:0]   word0_q, word0_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic              rsp_fault_q, rsp_fault_d;

  // Request decode, evaluated on the incoming request while IDLE.
  logic [OFF_W-1:0] req_off;
  logic [3:0]       req_size;
  logic [2:0]       req_mask;
  logic             legal, misaligned, req_split, req_fault;

  always_comb begin
    req_off    = bus.req_addr[OFF_W-1:0];
    req_size   = 4'd1 << bus.req_funct3[1:0];
    req_mask   = 3'(req_size - 4'd1);
    misaligned = |(bus.req_addr[2:0] & req_mask);
    req_split  = (5'(req_off) + 5'(req_size)) > 5'(BYTES);
    legal      = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
      3'b011, 3'b110:                         legal = (XLEN == 64);
      default:                                legal = 1'b0;
    endcase
    req_fault = !legal || (misaligned && !SUPPORT_MISALIGNED);
  end

  // Merge the returned word(s), shift the addressed byte to lane 0, then extend.
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   raw, loaded;
  logic [6:0]        nbits;
  logic              sbit;

  always_comb begin
    merged = '0;
    if (split_q) merged = {bus.mem_rdata, word0_q};
    else         merged[XLEN-1:0] = bus.mem_rdata;
    raw   = XLEN'(merged >> {off_q, 3'b000});
    nbits = 7'd8 << funct3_q[1:0];
    sbit  = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i == 32'(nbits) - 1) sbit = raw[i];
    end
    sbit = sbit & ~funct3_q[2];
    loaded = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      loaded[i] = (i < 32'(nbits)) ? raw[i] : sbit;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    split_d     = split_q;
    word0_d     = word0_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          off_d    = req_off;
          funct3_d = bus.req_funct3;
          rd_d     = bus.req_rd;
          split_d  = req_split;
          if (req_fault) begin
            rsp_fault_d = 1'b1;
            rsp_data_d  = '0;
            rsp_rd_d    = bus.req_rd;
            state_d     = RESP;
          end else begin
            mem_addr_d = bus.req_addr & ~ADDR_W'(BYTES - 1);
            state_d    = REQ0;
          end
        end
      end
      REQ0: if (bus.mem_req_ready) state_d = WAIT0;
      WAIT0: begin
        if (bus.mem_resp_valid) begin
          if (split_q) begin
            word0_d    = bus.mem_rdata;
            mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
            state_d    = REQ1;
          end else begin
            rsp_data_d  = loaded;
            rsp_rd_d    = rd_q;
            rsp_fault_d = 1'b0;
            state_d     = RESP;
          end
        end
      end
      REQ1: if (bus.mem_req_ready) state_d = WAIT1;
      WAIT1: begin
        if (bus.mem_resp_valid) begin
          rsp_data_d  = loaded;
          rsp_rd_d    = rd_q;
          rsp_fault_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      split_q     <= 1'b0;
      word0_q     <= '0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      split_q     <= split_d;
      word0_q     <= word0_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.mem_req_valid = (state_q == REQ0) || (state_q == REQ1);
  assign bus.mem_addr      = mem_addr_q;
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_rd        = rsp_rd_q;
  assign bus.rsp_fault     = rsp_fault_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: three configurations (32-bit, 32-bit without
// misaligned support, 64-bit) share one stimulus bus selected by 'sel'.
module tb_load_align_unit;
  logic        clk = 1'b0;
  logic        reset;
  int unsigned sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_req_ready, mem_resp_valid, rsp_ready;
  logic [63:0] mem_rdata;

  logic        obs_req_ready, obs_mem_req_valid, obs_rsp_valid, obs_rsp_fault;
  logic [31:0] obs_mem_addr;
  logic [63:0] obs_rsp_data;
  logic [4:0]  obs_rsp_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b0 ();
  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b1 ();
  load_align_unit_if #(.XLEN(64), .ADDR_W(32)) b2 ();

  load_align_unit #(.XLEN(32), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b1)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
  load_align_unit #(.XLEN(32), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b0)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  load_align_unit #(.XLEN(64), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b1)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));

  assign b0.req_valid = req_valid && (sel == 0);
  assign b1.req_valid = req_valid && (sel == 1);
  assign b2.req_valid = req_valid && (sel == 2);
  assign b0.req_addr = req_addr;     assign b1.req_addr = req_addr;     assign b2.req_addr = req_addr;
  assign b0.req_funct3 = req_funct3; assign b1.req_funct3 = req_funct3; assign b2.req_funct3 = req_funct3;
  assign b0.req_rd = req_rd;         assign b1.req_rd = req_rd;         assign b2.req_rd = req_rd;
  assign b0.mem_req_ready = mem_req_ready;   assign b1.mem_req_ready = mem_req_ready;   assign b2.mem_req_ready = mem_req_ready;
  assign b0.mem_resp_valid = mem_resp_valid; assign b1.mem_resp_valid = mem_resp_valid; assign b2.mem_resp_valid = mem_resp_valid;
  assign b0.mem_rdata = mem_rdata[31:0];     assign b1.mem_rdata = mem_rdata[31:0];     assign b2.mem_rdata = mem_rdata;
  assign b0.rsp_ready = rsp_ready;   assign b1.rsp_ready = rsp_ready;   assign b2.rsp_ready = rsp_ready;

  assign obs_req_ready     = (sel == 2) ? b2.req_ready     : (sel == 1) ? b1.req_ready     : b0.req_ready;
  assign obs_mem_req_valid = (sel == 2) ? b2.mem_req_valid : (sel == 1) ? b1.mem_req_valid : b0.mem_req_valid;
  assign obs_mem_addr      = (sel == 2) ? b2.mem_addr      : (sel == 1) ? b1.mem_addr      : b0.mem_addr;
  assign obs_rsp_valid     = (sel == 2) ? b2.rsp_valid     : (sel == 1) ? b1.rsp_valid     : b0.rsp_valid;
  assign obs_rsp_fault     = (sel == 2) ? b2.rsp_fault     : (sel == 1) ? b1.rsp_fault     : b0.rsp_fault;
  assign obs_rsp_rd        = (sel == 2) ? b2.rsp_rd        : (sel == 1) ? b1.rsp_rd        : b0.rsp_rd;
  assign obs_rsp_data      = (sel == 2) ? b2.rsp_data      : {32'h0, (sel == 1) ? b1.rsp_data : b0.rsp_data};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One load with a one-cycle memory and rsp_ready=1; cycle 0 is the accept cycle.
  task automatic run_load(input string tag, input int unsigned s, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [4:0] rd,
                          input logic [63:0] w0, input logic [63:0] w1,
                          input int exp_nreq, input logic [31:0] exp_a0, input logic [31:0] exp_a1,
                          input logic exp_fault, input logic [63:0] exp_data);
    int cyc, nseen, exp_lat;
    logic resp_due;
    logic [31:0] a_seen [2];
    exp_lat = (exp_nreq == 0) ? 1 : (exp_nreq == 1) ? 3 : 5;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_addr = addr; req_funct3 = f3; req_rd = rd;
    mem_req_ready = 1'b1; rsp_ready = 1'b1; mem_resp_valid = 1'b0;
    #1 chk({tag, ".req_ready"}, 64'(obs_req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; nseen = 0; resp_due = 1'b0; a_seen[0] = '0; a_seen[1] = '0;
    while (cyc < 20) begin
      mem_resp_valid = 1'b0;
      if (obs_rsp_valid) break;
      if (resp_due) begin
        mem_resp_valid = 1'b1;
        mem_rdata = (nseen == 1) ? w0 : w1;
        resp_due = 1'b0;
      end
      if (obs_mem_req_valid) begin
        if (nseen < 2) a_seen[nseen] = obs_mem_addr;
        nseen++;
        resp_due = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    mem_resp_valid = 1'b0;
    chk({tag, ".rsp_valid"}, 64'(obs_rsp_valid), 64'd1);
    chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, ".nreq"}, 64'(nseen), 64'(exp_nreq));
    if (exp_nreq > 0) chk({tag, ".addr0"}, 64'(a_seen[0]), 64'(exp_a0));
    if (exp_nreq > 1) chk({tag, ".addr1"}, 64'(a_seen[1]), 64'(exp_a1));
    chk({tag, ".data"}, obs_rsp_data, exp_data);
    chk({tag, ".fault"}, 64'(obs_rsp_fault), 64'(exp_fault));
    chk({tag, ".rd"}, 64'(obs_rsp_rd), 64'(rd));
    @(negedge clk);
    chk({tag, ".idle_after"}, 64'(obs_req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.req_ready", 64'(obs_req_ready), 64'd1);
    chk("rst.mem_req_valid", 64'(obs_mem_req_valid), 64'd0);
    chk("rst.rsp_valid", 64'(obs_rsp_valid), 64'd0);
    chk("rst.mem_addr", 64'(obs_mem_addr), 64'd0);
    chk("rst.rsp_data", obs_rsp_data, 64'd0);

    // XLEN=32, misaligned supported
    run_load("lb",   0, 3'b000, 32'h0000_0103, 5'd5,  64'h80FF1234, 64'h0, 1, 32'h100, 32'h0, 1'b0, 64'hFFFF_FF80);
    run_load("lbu",  0, 3'b100, 32'h0000_0103, 5'd6,  64'h80FF1234, 64'h0, 1, 32'h100, 32'h0, 1'b0, 64'h0000_0080);
    run_load("lhu",  0, 3'b101, 32'h0000_0102, 5'd7,  64'hBEEF0011, 64'h0, 1, 32'h100, 32'h0, 1'b0, 64'h0000_BEEF);
    run_load("lh",   0, 3'b001, 32'h0000_0102, 5'd8,  64'hBEEF0011, 64'h0, 1, 32'h100, 32'h0, 1'b0, 64'hFFFF_BEEF);
    run_load("lw_split", 0, 3'b010, 32'h0000_01FE, 5'd10, 64'hAABBCCDD, 64'h11223344, 2, 32'h1FC, 32'h200, 1'b0, 64'h3344_AABB);
    run_load("lw_wrap",  0, 3'b010, 32'hFFFF_FFFE, 5'd11, 64'hAABBCCDD, 64'h11223344, 2, 32'hFFFF_FFFC, 32'h0, 1'b0, 64'h3344_AABB);
    run_load("f3_111", 0, 3'b111, 32'h0000_0100, 5'd12, 64'h0, 64'h0, 0, 32'h0, 32'h0, 1'b1, 64'h0);
    run_load("ld_x32", 0, 3'b011, 32'h0000_0100, 5'd13, 64'h0, 64'h0, 0, 32'h0, 32'h0, 1'b1, 64'h0);
    // XLEN=32, misaligned not supported
    run_load("nomis_lh", 1, 3'b001, 32'h0000_0101, 5'd14, 64'h0, 64'h0, 0, 32'h0, 32'h0, 1'b1, 64'h0);
    run_load("nomis_lw", 1, 3'b010, 32'h0000_0100, 5'd15, 64'h12345678, 64'h0, 1, 32'h100, 32'h0, 1'b0, 64'h1234_5678);
    // XLEN=64
    run_load("lwu64", 2, 3'b110, 32'h0000_0014, 5'd16, 64'hDEADBEEF_01234567, 64'h0, 1, 32'h10, 32'h0, 1'b0, 64'h0000_0000_DEAD_BEEF);
    run_load("lw64",  2, 3'b010, 32'h0000_0014, 5'd17, 64'hDEADBEEF_01234567, 64'h0, 1, 32'h10, 32'h0, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);
    run_load("ld64",  2, 3'b011, 32'h0000_000C, 5'd18, 64'h07060504_03020100, 64'hDEADBEEF_01234567, 2, 32'h08, 32'h10, 1'b0, 64'h01234567_07060504);
    run_load("f3_111_64", 2, 3'b111, 32'h0000_0010, 5'd19, 64'h0, 64'h0, 0, 32'h0, 32'h0, 1'b1, 64'h0);

    // Backpressure on both the memory request and the response
    @(negedge clk);
    sel = 0; mem_req_ready = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h106; req_funct3 = 3'b001; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.mem_req_valid", 64'(obs_mem_req_valid), 64'd1);
      chk("bp.mem_addr", 64'(obs_mem_addr), 64'h104);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE0000; rsp_ready = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp.rsp_valid", 64'(obs_rsp_valid), 64'd1);
      chk("bp.rsp_data", obs_rsp_data, 64'hFFFF_CAFE);
      chk("bp.rsp_rd", 64'(obs_rsp_rd), 64'd9);
      @(negedge clk);
    end
    chk("bp.rsp_held", 64'(obs_rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.rsp_done", 64'(obs_rsp_valid), 64'd0);
    chk("bp.req_ready", 64'(obs_req_ready), 64'd1);

    // Reset in WAIT1 followed by a stale memory response
    req_valid = 1'b1; req_addr = 32'h1FE; req_funct3 = 3'b010; req_rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;                                  // cycle 1: REQ0
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 64'hAABBCCDD;   // cycle 2: WAIT0
    @(negedge clk);
    mem_resp_valid = 1'b0;                             // cycle 3: REQ1
    chk("rw.req1_addr", 64'(obs_mem_addr), 64'h200);
    @(negedge clk);
    reset = 1'b1;                                      // cycle 4: WAIT1
    @(negedge clk);
    reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h11223344;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("rw.rsp_valid", 64'(obs_rsp_valid), 64'd0);
    chk("rw.req_ready", 64'(obs_req_ready), 64'd1);
    chk("rw.mem_req_valid", 64'(obs_mem_req_valid), 64'd0);
    chk("rw.mem_addr", 64'(obs_mem_addr), 64'd0);
    @(negedge clk);
    chk("rw.rsp_valid2", 64'(obs_rsp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised load-data unit between the core's memory stage and the data memory port. It accepts one load request at a time and issues one word-aligned memory read, or two reads when the access straddles a word boundary. It merges the returned words, extracts the addressed byte/half/word/double, and sign- or zero-extends the result per RISC-V funct3. It returns the result with its destination-register tag and raises a fault for illegal or unsupported accesses.

Parameters:
XLEN, 32, data/memory word width in bits; legal values 32 or 64.
ADDR_W, 32, byte-address width.
SUPPORT_MISALIGNED, 1, 1 = misaligned loads are split and serviced; 0 = misaligned loads fault.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  load request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_addr  input  ADDR_W  byte address
req_funct3  input  3  RISC-V load funct3
req_rd  input  5  destination register tag, returned unchanged
mem_req_valid  output  1  memory read request
mem_req_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  word-aligned read address (low log2(XLEN/8) bits zero)
mem_resp_valid  input  1  read data valid
mem_rdata  input  XLEN  read data, little-endian byte lanes
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_data  output  XLEN  extended load result
rsp_rd  output  5  tag of the result
rsp_fault  output  1  1 = illegal funct3 or disallowed misalignment; rsp_data = 0

Behaviour:
- Reset (synchronous, dominates all inputs):
  - state goes to IDLE.
  - mem_req_valid, rsp_valid, rsp_fault = 0; mem_addr, rsp_data, rsp_rd = 0; req_ready = 1 in the cycle after reset.
  - Reset mid-operation abandons the access. mem_resp_valid is ignored in every state except WAIT0/WAIT1.
- States:
  - IDLE -> (accept) REQ0 | RESP (fault).
  - REQ0 -> (mem_req_ready) WAIT0.
  - WAIT0 -> (mem_resp_valid) REQ1 if split, else RESP.
  - REQ1 -> (mem_req_ready) WAIT1.
  - WAIT1 -> (mem_resp_valid) RESP.
  - RESP -> (rsp_ready) IDLE.
- Accept: req_valid && req_ready in IDLE. addr, funct3 and rd are captured.
- Legal funct3:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - XLEN=64 additionally: 011 LD, 110 LWU.
  - All other codes fault.
- Size and alignment:
  - size = 1 << funct3[1:0] bytes; off = addr mod (XLEN/8).
  - misaligned = addr mod size != 0; split = off + size > XLEN/8.
- Fault path (illegal funct3, or misaligned with SUPPORT_MISALIGNED=0): no memory request is issued. Go to RESP with rsp_fault=1 and rsp_data=0.
- Addressing and merge:
  - REQ0 mem_addr = addr with low bits cleared. REQ1 mem_addr = REQ0 address + XLEN/8, wrapping modulo 2^ADDR_W.
  - Merge: {second_word, first_word} >> (8*off); keep the low size bytes.
  - Extension: funct3[2]=0 -> sign-extend from the top loaded bit; funct3[2]=1 -> zero-extend. LW on XLEN=32 passes through unchanged.
- Handshakes:
  - mem_req_valid is high only in REQ0/REQ1. mem_addr is held stable until mem_req_ready.
  - mem_resp_valid is sampled at the earliest one cycle after the request handshake.
  - rsp_valid, rsp_data, rsp_rd and rsp_fault are registered and held stable while rsp_valid && !rsp_ready.
  - No new request is accepted until the RESP handshake completes (req_ready=0 outside IDLE).
- Latency, with mem_req_ready=1, one-cycle memory response and rsp_ready=1 (accept = cycle 0):
  - aligned: rsp_valid at cycle 3.
  - split: rsp_valid at cycle 5.
  - fault: rsp_valid at cycle 1.
  - Back-to-back: the next accept is possible in the cycle after the RESP handshake.

Test Plan:
- XLEN=32, LB (000) addr 0x103, mem[0x100]=0x80FF1234 -> single mem_addr 0x100; rsp_data=0xFFFFFF80; rsp_rd echoed; rsp_valid at cycle 3.
- LHU (101) addr 0x102, mem[0x100]=0xBEEF0011 -> rsp_data=0x0000BEEF; LH (001) same address -> 0xFFFFBEEF.
- LW (010) addr 0x1FE, mem[0x1FC]=0xAABBCCDD, mem[0x200]=0x11223344 -> mem_addr 0x1FC then 0x200; rsp_data=0x3344AABB at cycle 5. Repeat at addr 0xFFFFFFFE -> second mem_addr wraps to 0x00000000.
- SUPPORT_MISALIGNED=0, LH addr 0x101; separately funct3=111 (any config) -> mem_req_valid never asserted; rsp_fault=1, rsp_data=0, rsp_valid at cycle 1.
- XLEN=64, LWU (110) addr 0x14, mem[0x10]=0xDEADBEEF_01234567 -> rsp_data=0x00000000DEADBEEF; LD (011) addr 0x0C splits across 0x08/0x10.
- Backpressure and reset:
  - Hold mem_req_ready=0 for 3 cycles -> mem_addr stable.
  - Hold rsp_ready=0 for 2 cycles -> rsp_* stable.
  - Assert reset in WAIT1, then drive a stale mem_resp_valid -> IDLE, no rsp_valid, req_ready=1.
